pingpong_frame_ram: RTL and testbench
=====================================

// Module: pingpong_frame_ram
// PURPOSE
//  Double-buffered (ping-pong) frame store built from two DEPTH-deep banks.
//  A writer fills the back bank while a reader scans the front bank.
//  Banks swap only on a reader frame boundary, so the display never shows a torn frame.
//  Sits between the frame renderer and the OLED/SPI streaming engine.
//  Adds parametrised read latency, a swap handshake and frame accounting to the plain BRAM.
// PARAMETERS
//  ADDR_WIDTH    10  address bits per bank; DEPTH = 1<<ADDR_WIDTH words per bank
//  DATA_WIDTH    8   word width
//  READ_LATENCY  1   1 or 2; cycles from rd_en to rd_valid (2 adds an output register)
//  CNT_WIDTH     16  width of frame_count
// PORTS
//  clk           in   1           single clock, all logic on posedge
//  rst           in   1           synchronous reset, active-high
//  wr_en         in   1           write strobe to back bank; honoured only when wr_ready=1
//  wr_addr       in   ADDR_WIDTH  back-bank write address
//  wr_data       in   DATA_WIDTH  write data
//  wr_done       in   1           pulse: writer has finished the frame; honoured only when wr_ready=1
//  wr_ready      out  1           1 = back bank writable (state FILL)
//  rd_en         in   1           read strobe from front bank
//  rd_addr       in   ADDR_WIDTH  front-bank read address
//  rd_data       out  DATA_WIDTH  read data, qualified by rd_valid
//  rd_valid      out  1           rd_data valid; one pulse per accepted rd_en
//  rd_sync       in   1           pulse: reader is at a frame boundary; swap allowed this cycle
//  front_bank    out  1           index of the bank currently being read
//  swap_pulse    out  1           1-cycle pulse on the cycle after a swap commits
//  frame_count   out  CNT_WIDTH   number of committed swaps; wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset values: front_bank=0, wr_ready=1, rd_valid=0, rd_data=0, swap_pulse=0, frame_count=0.
//  Reset: state=FILL; in-flight reads discarded; RAM contents NOT cleared.
//  Bank mapping: back bank = ~front_bank. Physical address = {bank, addr}.
//  Reads:
//   - rd_en at cycle T samples rd_addr and front_bank at T.
//   - rd_data/rd_valid appear at T+READ_LATENCY.
//   - Back-to-back reads are accepted every cycle; no stall exists.
//   - A read issued in the swap cycle uses the pre-swap front bank.
//  Writes: when wr_en=1 and wr_ready=1, the back bank is written at posedge. wr_en while wr_ready=0
//   is ignored and must not modify either bank.
//  FSM (2 states):
//   FILL    : wr_ready=1.
//             - wr_done & rd_sync (same cycle): commit swap, stay in FILL.
//             - wr_done & !rd_sync: go to PENDING.
//             - A write in the same cycle as wr_done is accepted as the last word of the frame.
//   PENDING : wr_ready=0.
//             - rd_sync: commit swap, go to FILL.
//             - wr_done is ignored here.
//  Swap commit at edge T:
//   - front_bank toggles, so it shows the new value at T+1.
//   - frame_count increments at T+1; all-ones wraps to 0.
//   - swap_pulse=1 for cycle T+1 only.
//  rd_sync in FILL without wr_done: no swap; reader re-shows the same frame.
//  The writer must not write the new back bank (old front) before wr_ready=1. This is guaranteed
//   because wr_ready returns only after the swap.
//  rst asserted mid-PENDING or mid-read: the pending swap is dropped; state per reset values next cycle.
// TESTING
//  1 Reset, RL=1: write 0xA5 @addr 3 of bank1, wr_done+rd_sync same cycle; rd_en @3 next cycle
//    -> rd_data=0xA5 with rd_valid 1 cycle later; front_bank=1; frame_count=1; swap_pulse for 1 cycle.
//  2 wr_done without rd_sync -> wr_ready=0. A wr_en @3 data 0xFF while pending -> ignored.
//    rd_sync 5 cycles later -> swap; wr_ready=1 next cycle; readback of bank shows old data, not 0xFF.
//  3 RL=2: rd_en on 4 consecutive cycles at addrs 0..3 -> 4 consecutive rd_valid pulses,
//    starting 2 cycles later, with data in order.
//  4 rd_en in the same cycle as a swap commit -> data returned from the old front bank.
//    rd_en in the following cycle -> data from the new front bank.
//  5 CNT_WIDTH=2: 5 swaps -> frame_count sequence 1,2,3,0,1.
//  6 rst asserted while PENDING with a read in flight -> next cycle rd_valid=0, wr_ready=1, front_bank=0,
//    frame_count=0; no swap_pulse.

Source files
------------

// File: rtl/pingpong_frame_ram.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_frame_ram
//  Brief    : Double-buffered frame store. The writer fills the back bank
//             while the reader scans the front bank. Banks swap only on a
//             reader frame boundary, so the display never shows a torn frame.
//  Revision : 1.0 - initial release
// ============================================================================
module pingpong_frame_ram #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_sync,
    output logic                  front_bank,
    output logic                  swap_pulse,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    // Both banks live in one array; the bank index is the address MSB.
    localparam int unsigned c_WORDS = 2 * (1 << ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_FILL    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_swap;
    logic                   w_wr_ready;
    logic                   r_front;
    logic                   r_swap_pulse;
    logic [CNT_WIDTH-1:0]   r_frame_count;
    logic [DATA_WIDTH-1:0]  r_mem [0:c_WORDS-1];
    logic [DATA_WIDTH-1:0]  r_rd_data_s1;
    logic                   r_rd_valid_s1;

    // State register; reset drops any pending swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, swap decision and writer handshake.
    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        w_wr_ready   = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_wr_ready = 1'b1;
                if (wr_done) begin
                    if (rd_sync) begin
                        w_swap = 1'b1;
                    end else begin
                        w_state_next = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (rd_sync) begin
                    w_swap       = 1'b1;
                    w_state_next = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    // Bank select, swap strobe and frame accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_front       <= 1'b0;
            r_swap_pulse  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_swap_pulse <= w_swap;
            if (w_swap) begin
                r_front       <= ~r_front;
                r_frame_count <= r_frame_count + c_CNT_ONE;
            end
        end
    end

    // Writer port: back bank only, and only while the writer owns it.
    // Contents are deliberately not cleared on reset.
    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ready) begin
            r_mem[{~r_front, wr_addr}] <= wr_data;
        end
    end

    // Reader first stage: samples the pre-swap front bank in a swap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid_s1 <= 1'b0;
            r_rd_data_s1  <= '0;
        end else begin
            r_rd_valid_s1 <= rd_en;
            if (rd_en) begin
                r_rd_data_s1 <= r_mem[{r_front, rd_addr}];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_rl2
            logic [DATA_WIDTH-1:0] r_rd_data_s2;
            logic                  r_rd_valid_s2;

            // Optional output register for timing closure.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_valid_s2 <= 1'b0;
                    r_rd_data_s2  <= '0;
                end else begin
                    r_rd_valid_s2 <= r_rd_valid_s1;
                    r_rd_data_s2  <= r_rd_data_s1;
                end
            end

            assign rd_data  = r_rd_data_s2;
            assign rd_valid = r_rd_valid_s2;
        end else begin : g_rl1
            assign rd_data  = r_rd_data_s1;
            assign rd_valid = r_rd_valid_s1;
        end
    endgenerate

    assign wr_ready    = w_wr_ready;
    assign front_bank  = r_front;
    assign swap_pulse  = r_swap_pulse;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_frame_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pingpong_frame_ram
//  Brief    : Self-checking bench for pingpong_frame_ram. Two instances share
//             one stimulus stream: RL=1 with a 2-bit frame counter, and RL=2
//             with a 16-bit counter. Reads are scored through per-DUT queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pingpong_frame_ram;

    localparam int c_AW = 4;
    localparam int c_DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0;
    logic [c_AW-1:0] wr_addr = '0;
    logic [c_DW-1:0] wr_data = '0;
    logic            wr_done = 1'b0;
    logic            rd_en = 1'b0;
    logic [c_AW-1:0] rd_addr = '0;
    logic            rd_sync = 1'b0;

    logic            wr_ready1, wr_ready2;
    logic [c_DW-1:0] rd_data1, rd_data2;
    logic            rd_valid1, rd_valid2;
    logic            front1, front2;
    logic            swap1, swap2;
    logic [1:0]      cnt1;
    logic [15:0]     cnt2;

    pingpong_frame_ram #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .READ_LATENCY(1), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done), .wr_ready(wr_ready1), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_sync(rd_sync),
        .front_bank(front1), .swap_pulse(swap1), .frame_count(cnt1)
    );

    pingpong_frame_ram #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .READ_LATENCY(2), .CNT_WIDTH(16)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done), .wr_ready(wr_ready2), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_sync(rd_sync),
        .front_bank(front2), .swap_pulse(swap2), .frame_count(cnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [c_DW-1:0] m_mem [0:(2<<c_AW)-1];
    logic            m_front = 1'b0;
    logic            m_fill  = 1'b1;
    int              m_cnt   = 0;
    logic [c_DW-1:0] q1 [$];
    logic [c_DW-1:0] q2 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read-return monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rd_valid1 === 1'b1) begin
            if (q1.size() == 0) chk("rd1_spurious", 32'(rd_valid1), 32'd0);
            else chk("rd1_data", 32'(rd_data1), 32'(q1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rd_valid2 === 1'b1) begin
            if (q2.size() == 0) chk("rd2_spurious", 32'(rd_valid2), 32'd0);
            else chk("rd2_data", 32'(rd_data2), 32'(q2.pop_front()));
        end
    end

    task automatic do_write(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (m_fill) m_mem[{~m_front, a}] = d;
    endtask

    task automatic drive_read(input logic [c_AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        q1.push_back(m_mem[{m_front, a}]);
        q2.push_back(m_mem[{m_front, a}]);
    endtask

    // One clock: predict swap, advance, update reference, release strobes, check.
    task automatic step();
        logic sw;
        sw = 1'b0;
        if (!rst) sw = m_fill ? (wr_done && rd_sync) : rd_sync;
        @(posedge clk);
        #1;
        if (rst) begin
            m_front = 1'b0;
            m_fill  = 1'b1;
            m_cnt   = 0;
            q1.delete();
            q2.delete();
        end else begin
            if (m_fill && wr_done && !rd_sync) m_fill = 1'b0;
            else if (!m_fill && rd_sync) m_fill = 1'b1;
            if (sw) begin
                m_front = ~m_front;
                m_cnt++;
            end
        end
        wr_en = 1'b0; wr_done = 1'b0; rd_sync = 1'b0; rd_en = 1'b0;
        chk("front1", 32'(front1), 32'(m_front));
        chk("front2", 32'(front2), 32'(m_front));
        chk("ready1", 32'(wr_ready1), 32'(m_fill));
        chk("ready2", 32'(wr_ready2), 32'(m_fill));
        chk("cnt1", 32'(cnt1), 32'(m_cnt & 3));
        chk("cnt2", 32'(cnt2), 32'(m_cnt & 16'hFFFF));
        chk("swap1", 32'(swap1), 32'(sw));
        chk("swap2", 32'(swap2), 32'(sw));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        chk("rst_valid1", 32'(rd_valid1), 32'd0);
        chk("rst_valid2", 32'(rd_valid2), 32'd0);
        chk("rst_data1", 32'(rd_data1), 32'd0);
        chk("rst_data2", 32'(rd_data2), 32'd0);
        rst = 1'b0;
        step();

        // Write bank1 @3 with done+sync together, then read it back.
        do_write(4'd3, 8'hA5);
        wr_done = 1'b1;
        rd_sync = 1'b1;
        step();
        chk("t1_front", 32'(front1), 32'd1);
        chk("t1_swap", 32'(swap1), 32'd1);
        drive_read(4'd3);
        step();
        chk("t1_swap_gone", 32'(swap1), 32'd0);
        step();
        step();

        // Pending swap; writes while pending are ignored.
        do_write(4'd3, 8'h3C);
        wr_done = 1'b1;
        step();
        chk("t2_ready", 32'(wr_ready1), 32'd0);
        do_write(4'd3, 8'hFF);
        step();
        drive_read(4'd3);
        wr_done = 1'b1;
        step();
        step();
        step();
        rd_sync = 1'b1;
        step();
        chk("t2_ready_back", 32'(wr_ready2), 32'd1);
        drive_read(4'd3);
        step();
        step();
        step();

        // Fill bank1 addrs 0..3, swap, then four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            do_write(c_AW'(i), 8'h10 + c_DW'(i));
            if (i == 3) begin
                wr_done = 1'b1;
                rd_sync = 1'b1;
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive_read(c_AW'(i));
            step();
            if (i == 0) begin
                chk("t3_v1_first", 32'(rd_valid1), 32'd1);
                chk("t3_v2_first", 32'(rd_valid2), 32'd0);
            end else begin
                chk("t3_v2_run", 32'(rd_valid2), 32'd1);
            end
        end
        step();
        chk("t3_v1_tail", 32'(rd_valid1), 32'd0);
        chk("t3_v2_tail", 32'(rd_valid2), 32'd1);
        step();
        chk("t3_v2_end", 32'(rd_valid2), 32'd0);

        // Read in the swap cycle returns the old front; next cycle the new one.
        do_write(4'd1, 8'h77);
        wr_done = 1'b1;
        rd_sync = 1'b1;
        drive_read(4'd1);
        step();
        drive_read(4'd1);
        step();
        chk("t4_cnt_wrap", 32'(cnt1), 32'd0);
        step();
        step();

        // rd_sync alone never swaps; then counter wrap sequence.
        rd_sync = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            wr_done = 1'b1;
            rd_sync = 1'b1;
            step();
        end
        chk("t5_cnt1", 32'(cnt1), 32'd0);
        chk("t5_cnt2", 32'(cnt2), 32'd8);

        // Reset while pending, with reads in flight and a sync asserted.
        wr_done = 1'b1;
        step();
        drive_read(4'd1);
        step();
        rst = 1'b1;
        rd_sync = 1'b1;
        drive_read(4'd1);
        step();
        rst = 1'b0;
        chk("t6_valid1", 32'(rd_valid1), 32'd0);
        chk("t6_valid2", 32'(rd_valid2), 32'd0);
        chk("t6_ready", 32'(wr_ready1), 32'd1);
        chk("t6_front", 32'(front2), 32'd0);
        chk("t6_cnt", 32'(cnt2), 32'd0);
        chk("t6_swap", 32'(swap2), 32'd0);
        step();
        step();
        step();
        chk("q1_drain", 32'(q1.size()), 32'd0);
        chk("q2_drain", 32'(q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
